// File: rtl/md5_pkg.sv
// MD5 constants, schedule helpers and FSM state type
// shared by the compression core and its step datapath.
package md5_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [31:0] INIT_A = 32'h67452301;
  localparam logic [31:0] INIT_B = 32'hefcdab89;
  localparam logic [31:0] INIT_C = 32'h98badcfe;
  localparam logic [31:0] INIT_D = 32'h10325476;

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S_TAB [4][4] = '{
    '{5'd7, 5'd12, 5'd17, 5'd22},
    '{5'd5, 5'd9,  5'd14, 5'd20},
    '{5'd4, 5'd11, 5'd16, 5'd23},
    '{5'd6, 5'd10, 5'd15, 5'd21}
  };

  // 4-bit arithmetic gives the mod-16 wrap for free
  function automatic logic [3:0] msg_idx(input logic [5:0] j);
    logic [3:0] jl;
    logic [3:0] g;
    jl = j[3:0];
    unique case (j[5:4])
      2'd0:    g = jl;
      2'd1:    g = jl * 4'd5 + 4'd1;
      2'd2:    g = jl * 4'd3 + 4'd5;
      default: g = jl * 4'd7;
    endcase
    return g;
  endfunction

  function automatic logic [31:0] rotl32(
    input logic [31:0] x,
    input logic [4:0]  s
  );
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: round function, schedule,
// rotate and register rotation of A..D.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  input  logic [31:0]  c,
  input  logic [31:0]  d,
  input  logic [5:0]   j,
  input  logic [511:0] m,
  output logic [31:0]  a_n,
  output logic [31:0]  b_n,
  output logic [31:0]  c_n,
  output logic [31:0]  d_n
);

  logic [1:0]  r;
  logic [3:0]  g;
  logic [31:0] f;
  logic [31:0] w;
  logic [31:0] t;

  assign r = j[5:4];
  assign g = msg_idx(j);
  assign w = m[{g, 5'd0} +: 32];

  always_comb begin
    f = '0;
    unique case (r)
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (b & d) | (c & ~d);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
  end

  assign t   = a + f + K[j] + w;
  assign b_n = b + rotl32(t, S_TAB[r][j[1:0]]);
  assign a_n = d;
  assign c_n = b;
  assign d_n = c;

endmodule

// File: rtl/md5_compress_core.sv
// MD5 compression of one 512-bit block, STEPS_PER_CYC steps
// per clock, valid/ready on input and digest output.
module md5_compress_core
  import md5_pkg::*;
#(
  parameter int N             = 32,
  parameter int STEPS_PER_CYC = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [511:0] msg_i,
  input  logic [127:0] chain_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] digest_o,
  output logic         busy_o
);

  localparam int CYCLES = 64 / STEPS_PER_CYC;
  localparam logic [5:0] J_INC  = 6'(STEPS_PER_CYC);
  localparam logic [5:0] J_LAST = 6'((CYCLES - 1) * STEPS_PER_CYC);

  if (N != 32) begin : g_bad_n
    $error("md5_compress_core: N must be 32");
  end
  if (STEPS_PER_CYC != 1 && STEPS_PER_CYC != 2 &&
      STEPS_PER_CYC != 4) begin : g_bad_s
    $error("md5_compress_core: STEPS_PER_CYC must be 1, 2 or 4");
  end

  state_t         state;
  state_t         state_n;
  logic [5:0]     j_q;
  logic [511:0]   m_q;
  logic [127:0]   chain_q;
  logic [127:0]   digest_q;
  logic [31:0]    a_q, b_q, c_q, d_q;
  logic           accept;
  logic           last;

  logic [STEPS_PER_CYC:0][31:0] sa, sb, sc, sd;

  assign sa[0] = a_q;
  assign sb[0] = b_q;
  assign sc[0] = c_q;
  assign sd[0] = d_q;

  for (genvar i = 0; i < STEPS_PER_CYC; i++) begin : g_step
    md5_step u_step (
      .a   (sa[i]),
      .b   (sb[i]),
      .c   (sc[i]),
      .d   (sd[i]),
      .j   (j_q + 6'(i)),
      .m   (m_q),
      .a_n (sa[i+1]),
      .b_n (sb[i+1]),
      .c_n (sc[i+1]),
      .d_n (sd[i+1])
    );
  end

  assign accept = (state == IDLE) && in_valid_i;
  assign last   = (state == RUN) && (j_q == J_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid_i)  state_n = RUN;
      RUN:     if (last)        state_n = DONE;
      DONE:    if (out_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      j_q      <= '0;
      m_q      <= '0;
      chain_q  <= '0;
      digest_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
    end else if (accept) begin
      m_q     <= msg_i;
      chain_q <= chain_i;
      a_q     <= chain_i[31:0];
      b_q     <= chain_i[63:32];
      c_q     <= chain_i[95:64];
      d_q     <= chain_i[127:96];
      j_q     <= '0;
    end else if (state == RUN) begin
      a_q <= sa[STEPS_PER_CYC];
      b_q <= sb[STEPS_PER_CYC];
      c_q <= sc[STEPS_PER_CYC];
      d_q <= sd[STEPS_PER_CYC];
      // 6-bit counter wraps to 0 on the final increment
      j_q <= j_q + J_INC;
      if (last) begin
        digest_q <= {chain_q[127:96] + sd[STEPS_PER_CYC],
                     chain_q[95:64]  + sc[STEPS_PER_CYC],
                     chain_q[63:32]  + sb[STEPS_PER_CYC],
                     chain_q[31:0]   + sa[STEPS_PER_CYC]};
      end
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign digest_o    = digest_q;

endmodule

// File: tb/tb_md5_compress_core.sv
// Bench for md5_compress_core: three instances at 1, 2 and 4
// steps per clock, checked against known digests and a model.
module tb_md5_compress_core;

  localparam logic [127:0] INIT =
    {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
  localparam logic [127:0] EMPTY_D =
    {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
  localparam logic [127:0] ABC_D =
    {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         out_ready [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [511:0] msg       [3];
  logic [127:0] chain     [3];
  logic [127:0] digest    [3];

  logic [31:0]  kt [64];
  logic [127:0] sb [$];
  logic [511:0] m_empty, m_abc;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    md5_compress_core #(.N(32), .STEPS_PER_CYC(1 << g)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .msg_i       (msg[g]),
      .chain_i     (chain[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .digest_o    (digest[g]),
      .busy_o      (busy[g])
    );
  end

  function automatic logic [127:0] md5_model(
    input logic [511:0] m,
    input logic [127:0] ch
  );
    int st [16] = '{7, 12, 17, 22, 5, 9, 14, 20,
                    4, 11, 16, 23, 6, 10, 15, 21};
    logic [31:0] a, b, c, d, f, t;
    int g, s;
    a = ch[31:0];
    b = ch[63:32];
    c = ch[95:64];
    d = ch[127:96];
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin
        f = (b & c) | (~b & d); g = i;
      end else if (i < 32) begin
        f = (d & b) | (~d & c); g = (5 * i + 1) % 16;
      end else if (i < 48) begin
        f = b ^ c ^ d; g = (3 * i + 5) % 16;
      end else begin
        f = c ^ (b | ~d); g = (7 * i) % 16;
      end
      s = st[(i / 16) * 4 + i % 4];
      t = a + f + kt[i] + m[g*32 +: 32];
      a = d;
      d = c;
      c = b;
      b = b + ((t << s) | (t >> (32 - s)));
    end
    return {ch[127:96] + d, ch[95:64] + c,
            ch[63:32] + b, ch[31:0] + a};
  endfunction

  task automatic send(
    input int d,
    input logic [511:0] m,
    input logic [127:0] ch
  );
    int to;
    to = 0;
    in_valid[d] = 1'b1;
    msg[d]      = m;
    chain[d]    = ch;
    while (!in_ready[d] && to < 500) begin
      @(negedge clk);
      to++;
    end
    sb.push_back(md5_model(m, ch));
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 1;
    while (!out_valid[d] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      msg[d]       = '0;
      chain[d]     = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total += 4;
      if (in_ready[d] !== 1'b1) begin
        bad++; $display("FAIL reset_in_ready d=%0d got=%b exp=1", d, in_ready[d]);
      end
      if (out_valid[d] !== 1'b0) begin
        bad++; $display("FAIL reset_out_valid d=%0d got=%b exp=0", d, out_valid[d]);
      end
      if (busy[d] !== 1'b0) begin
        bad++; $display("FAIL reset_busy d=%0d got=%b exp=0", d, busy[d]);
      end
      if (digest[d] !== 128'd0) begin
        bad++; $display("FAIL reset_digest d=%0d got=%h exp=0", d, digest[d]);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (busy[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
        bad++;
        $display("FAIL idle_after_reset d=%0d busy=%b ready=%b exp busy=0 ready=1",
                 d, busy[d], in_ready[d]);
      end
    end
  endtask

  task automatic test_known(
    input int d,
    input string name,
    input logic [511:0] m,
    input logic [127:0] exp
  );
    int lat;
    logic [127:0] e;
    out_ready[d] = 1'b1;
    sb.delete();
    send(d, m, INIT);
    wait_out(d, lat);
    total += 3;
    if (lat != (64 >> d) + 1) begin
      bad++; $display("FAIL %s_latency d=%0d got=%0d exp=%0d", name, d, lat, (64 >> d) + 1);
    end
    if (digest[d] !== exp) begin
      bad++; $display("FAIL %s_digest d=%0d got=%h exp=%h", name, d, digest[d], exp);
    end
    e = (sb.size() != 0) ? sb.pop_front() : 128'hx;
    if (digest[d] !== e) begin
      bad++; $display("FAIL %s_model d=%0d got=%h exp=%h", name, d, digest[d], e);
    end
    @(negedge clk);
    total++;
    if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
      bad++;
      $display("FAIL %s_release d=%0d valid=%b busy=%b exp 0 0", name, d, out_valid[d], busy[d]);
    end
  endtask

  task automatic test_backpressure(input int d);
    int lat;
    logic [127:0] e;
    sb.delete();
    out_ready[d] = 1'b0;
    send(d, m_abc, INIT);
    wait_out(d, lat);
    in_valid[d] = 1'b1;
    msg[d]      = m_empty;
    chain[d]    = INIT;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (digest[d] !== ABC_D || out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold d=%0d cyc=%0d dig=%h v=%b r=%b exp %h 1 0",
                 d, i, digest[d], out_valid[d], in_ready[d], ABC_D);
      end
      @(negedge clk);
    end
    out_ready[d] = 1'b1;
    void'(sb.pop_front());
    @(negedge clk);
    total++;
    if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
      bad++;
      $display("FAIL bp_release d=%0d ready=%b valid=%b exp 1 0", d, in_ready[d], out_valid[d]);
    end
    sb.push_back(md5_model(m_empty, INIT));
    @(negedge clk);
    in_valid[d] = 1'b0;
    total++;
    if (busy[d] !== 1'b1) begin
      bad++; $display("FAIL bp_second_accept d=%0d busy=%b exp=1", d, busy[d]);
    end
    wait_out(d, lat);
    e = (sb.size() != 0) ? sb.pop_front() : 128'hx;
    total += 2;
    if (digest[d] !== e) begin
      bad++; $display("FAIL bp_second_model d=%0d got=%h exp=%h", d, digest[d], e);
    end
    if (digest[d] !== EMPTY_D) begin
      bad++; $display("FAIL bp_second_digest d=%0d got=%h exp=%h", d, digest[d], EMPTY_D);
    end
    @(negedge clk);
  endtask

  task automatic test_chain(input int d);
    logic [511:0] m1, m2;
    logic [127:0] h1, e, e2;
    int lat;
    for (int i = 0; i < 64; i++) m1[8*i +: 8] = 8'(97 + i % 26);
    m2 = '0;
    m2[31:0]          = 32'h00000080;
    m2[14*32 +: 32]   = 32'h00000200;
    e2 = md5_model(m2, md5_model(m1, INIT));
    sb.delete();
    out_ready[d] = 1'b1;
    send(d, m1, INIT);
    wait_out(d, lat);
    e = (sb.size() != 0) ? sb.pop_front() : 128'hx;
    total++;
    if (digest[d] !== e) begin
      bad++; $display("FAIL chain_blk1 d=%0d got=%h exp=%h", d, digest[d], e);
    end
    h1 = digest[d];
    @(negedge clk);
    send(d, m2, h1);
    wait_out(d, lat);
    void'(sb.pop_front());
    total++;
    if (digest[d] !== e2) begin
      bad++; $display("FAIL chain_blk2 d=%0d got=%h exp=%h", d, digest[d], e2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid(input int d);
    int lat;
    sb.delete();
    out_ready[d] = 1'b1;
    send(d, m_abc, INIT);
    repeat (30) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total += 4;
    if (in_ready[d] !== 1'b1) begin
      bad++; $display("FAIL midrst_ready d=%0d got=%b exp=1", d, in_ready[d]);
    end
    if (out_valid[d] !== 1'b0) begin
      bad++; $display("FAIL midrst_valid d=%0d got=%b exp=0", d, out_valid[d]);
    end
    if (busy[d] !== 1'b0) begin
      bad++; $display("FAIL midrst_busy d=%0d got=%b exp=0", d, busy[d]);
    end
    if (digest[d] !== 128'd0) begin
      bad++; $display("FAIL midrst_digest d=%0d got=%h exp=0", d, digest[d]);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    send(d, m_abc, INIT);
    wait_out(d, lat);
    void'(sb.pop_front());
    total++;
    if (digest[d] !== ABC_D) begin
      bad++; $display("FAIL midrst_abc d=%0d got=%h exp=%h", d, digest[d], ABC_D);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back(input int d);
    int p, seen, lat;
    logic [127:0] e;
    sb.delete();
    out_ready[d] = 1'b1;
    send(d, m_abc, INIT);
    in_valid[d] = 1'b1;
    msg[d]      = m_empty;
    chain[d]    = INIT;
    p = 1;
    seen = 0;
    while (!in_ready[d] && p < 200) begin
      if (out_valid[d]) begin
        e = (sb.size() != 0) ? sb.pop_front() : 128'hx;
        total++;
        if (digest[d] !== e) begin
          bad++; $display("FAIL b2b_first d=%0d got=%h exp=%h", d, digest[d], e);
        end
        seen++;
      end
      @(negedge clk);
      p++;
    end
    total++;
    if (p != (64 >> d) + 2 || seen != 1) begin
      bad++;
      $display("FAIL b2b_period d=%0d got=%0d outs=%0d exp=%0d outs=1", d, p, seen, (64 >> d) + 2);
    end
    sb.push_back(md5_model(m_empty, INIT));
    @(negedge clk);
    in_valid[d] = 1'b0;
    wait_out(d, lat);
    e = (sb.size() != 0) ? sb.pop_front() : 128'hx;
    total++;
    if (digest[d] !== e) begin
      bad++; $display("FAIL b2b_second d=%0d got=%h exp=%h", d, digest[d], e);
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int d, input int nb);
    sb.delete();
    fork
      begin : drv
        logic [511:0] m;
        logic [127:0] ch;
        for (int n = 0; n < nb; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          for (int k = 0; k < 16; k++) m[k*32 +: 32] = $urandom();
          for (int k = 0; k < 4; k++) ch[k*32 +: 32] = $urandom();
          send(d, m, ch);
        end
      end
      begin : mon
        int got, cyc;
        logic [127:0] e;
        got = 0;
        cyc = 0;
        while (got < nb && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          out_ready[d] = 1'($urandom_range(0, 1));
          if (out_valid[d] && out_ready[d]) begin
            total++;
            if (sb.size() == 0) begin
              bad++; $display("FAIL rand_unexpected d=%0d got=%h exp=none", d, digest[d]);
            end else begin
              e = sb.pop_front();
              if (digest[d] !== e) begin
                bad++; $display("FAIL rand_digest d=%0d n=%0d got=%h exp=%h", d, got, digest[d], e);
              end
            end
            got++;
          end
        end
        total++;
        if (got != nb) begin
          bad++; $display("FAIL rand_timeout d=%0d got=%0d exp=%0d", d, got, nb);
        end
      end
    join
    out_ready[d] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      real v;
      v = $sin(i + 1.0);
      if (v < 0.0) v = -v;
      kt[i] = 32'($rtoi($floor(v * 4294967296.0) - 2147483648.0)) + 32'h80000000;
    end
    m_empty = '0;
    m_empty[31:0] = 32'h00000080;
    m_abc = '0;
    m_abc[31:0] = 32'h80636261;
    m_abc[14*32 +: 32] = 32'h00000018;

    test_reset();
    test_known(0, "empty", m_empty, EMPTY_D);
    test_known(1, "empty", m_empty, EMPTY_D);
    test_known(2, "empty", m_empty, EMPTY_D);
    test_known(0, "abc", m_abc, ABC_D);
    test_known(2, "abc", m_abc, ABC_D);
    test_backpressure(2);
    test_chain(1);
    test_reset_mid(0);
    test_back_to_back(2);
    test_back_to_back(0);
    test_random(0, 150);
    test_random(1, 150);
    test_random(2, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/md5_compress_core.md
Name: md5_compress_core

Overview:
- Full MD5 compression function for one 512-bit block.
- Covers all 64 steps across all four rounds, with a round-dependent message schedule and the final chaining add.
- Successor to the single-round computation block. Parametrised by steps unrolled per clock.
- Has valid/ready handshakes on both sides, so a padding/framing front-end can stream consecutive blocks into it.

Parameters:
- N, 32, word width. Only 32 is legal; elaborate-time assertion otherwise.
- STEPS_PER_CYC, 1, MD5 steps evaluated per clock. Legal values 1, 2, 4.
- CYCLES, 64/STEPS_PER_CYC, derived local parameter. Not overridable.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  block and chaining value are present.
- in_ready_o  out  1  core can accept a block.
- msg_i  in  512  message words, M[k] = msg_i[32k+31:32k]; words are already little-endian.
- chain_i  in  128  incoming chaining value {D,C,B,A}, A at [31:0].
- out_valid_o  out  1  digest_o valid.
- out_ready_i  in  1  consumer takes digest.
- digest_o  out  128  chaining result {D',C',B',A'}, same packing as chain_i.
- busy_o  out  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous assert):
  - state=IDLE, step counter j=0.
  - in_ready_o=1, out_valid_o=0, busy_o=0.
  - digest_o=0; A,B,C,D and all message/chain registers =0.
- Reset applies at any point mid-operation and discards the block in progress; no partial output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o: latch msg_i and chain_i, load A..D from chain_i, j=0, go to RUN.
- RUN:
  - in_ready_o=0; in_valid_i is ignored and nothing is latched.
  - Each clock, STEPS_PER_CYC chained steps execute for j..j+S-1, then j += S.
  - After the step with j=63: go to DONE and register digest_o = {D+Dc, C+Cc, B+Bc, A+Ac}, each add mod 2^32, carries discarded.
- Per step, with r = j[5:4]:
  - Function: r0 F=(B&C)|(~B&D); r1 G=(B&D)|(C&~D); r2 H=B^C^D; r3 I=C^(B|~D).
  - Message index g: r0 g=j; r1 g=(5j+1) mod 16; r2 g=(3j+5) mod 16; r3 g=(7j) mod 16.
  - Rotate amount s from {r, j[1:0]}: r0 7,12,17,22; r1 5,9,14,20; r2 4,11,16,23; r3 6,10,15,21.
  - Update: T = A+f+K[j]+M[g] (mod 2^32); B' = B + rotl(T,s); A'=D, C'=B, D'=C.
  - rotl with s in 4..23 only; there is no shift-by-32 case.
- DONE:
  - out_valid_o=1. digest_o is held stable until out_valid_o&out_ready_i.
  - On that handshake: go to IDLE.
  - in_ready_o=0 in DONE. No block is accepted in the same cycle as output release; the next block is accepted one cycle later at the earliest.
- Latency: out_valid_o rises exactly CYCLES+1 clocks after the accepting edge (65 at S=1, 17 at S=4). Throughput is one block per CYCLES+2 clocks with out_ready_i tied high.
- busy_o = (state != IDLE).
- in_ready_o and out_valid_o are combinational decodes of the registered state only; no combinational path from in_valid_i or out_ready_i.
- j wraps 63→0 on entry to DONE. The counter width is 6 bits. With S>1, j only ever takes multiples of S.

Decomposition:
- Package md5_pkg:
  - K[0:63] constant table (floor(abs(sin(i+1))·2^32)).
  - Shift table S_TAB[0:3][0:3].
  - Init constants 67452301, efcdab89, 98badcfe, 10325476.
  - Function msg_idx(j) and function rotl32.
  - Typedef state_t for the FSM.
- Sub-module md5_step: combinational single step.
  - Inputs: A,B,C,D, j, M array. Outputs: A',B',C',D'.
  - Instantiated STEPS_PER_CYC times in a generate chain.
- Top level holds the FSM, the counter and the registers.

Test Plan:
- Empty string: chain=init, M[0]=00000080, others 0 → digest A=d98c1dd4 B=04b2008f C=980980e9 D=7e42f8ec (d41d8cd98f00b204e9800998ecf8427e). out_valid_o exactly 65 clocks after accept at S=1 and 17 at S=4.
- "abc": M[0]=80636261, M[14]=00000018, others 0 → A=98500190 B=b04fd23c C=7d3f96d6 D=727fe128.
- Backpressure: hold out_ready_i=0 for 20 cycles after out_valid_o → digest_o stable, in_ready_o=0, a second in_valid_i is not accepted. Release → next block is accepted one cycle later and produces the correct digest.
- Chaining: two-block 64-char message → feed digest_o as chain_i of block 2; the result matches a reference model.
- Reset mid-RUN at j=30: all outputs return to reset values immediately. A new "abc" block then yields the correct digest with no contamination.
- Random: 500 random msg_i/chain_i at S=1,2,4 compared against the C model, with in_valid_i/out_ready_i toggled randomly.
